// File: rtl/jk_sched_pkg.sv
// jk_sched_pkg: shared types and defaults for the JK bank scheduler.
//   op_t    : per-requester {J,K} operation code (HOLD/CLR/SET/TOG)
//   state_t : scheduler FSM states
//   NREQ_DEF, WIDTH_DEF : default parameter values
package jk_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_TOG  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_APPLY,
    ST_ACK
  } state_t;

endpackage

// File: rtl/jk_bank_sched_cell.sv
// jk_ff_cell: a single JK flip-flop bit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q -> 0)
//   j, k  : JK inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   q, qb : state and its complement
module jk_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/jk_bank_sched.sv
// jk_bank_sched: round-robin scheduler that applies one requester's JK
// operation to a WIDTH-bit bank of JK flip-flops per transaction.
// Transaction: IDLE (arbitrate) -> LATCH (capture op/mask) -> APPLY (update q)
//              -> ACK (gnt pulse, advance pointer) -> IDLE.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sync_clr   : synchronous clear (only when JK_SCHED_SCLR_EN is defined)
//   req [NREQ]          : request levels
//   op  [2*NREQ]        : per-requester {J,K} code, requester i at [2i+1:2i]
//   mask[WIDTH*NREQ]    : per-requester bit select
//   gnt [NREQ]          : one-hot completion pulse during ACK
//   busy                : state is not IDLE
//   q, qb [WIDTH]       : bank state and complement
// Optional feature macro: JK_SCHED_SCLR_EN.
module jk_bank_sched
  import jk_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef JK_SCHED_SCLR_EN
  input  logic                  sync_clr,
`endif
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qb
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_nx;
  logic [IW-1:0]    ptr, win_r, pick, cand;
  logic             found;
  op_t              op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] j_v, k_v;
  logic             sclr;

`ifdef JK_SCHED_SCLR_EN
  assign sclr = sync_clr;
`else
  assign sclr = 1'b0;
`endif

  // Round-robin search starting at ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IW'((32'(ptr) + off) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (|req) state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_APPLY;
      ST_APPLY: state_nx = ST_ACK;
      ST_ACK:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (sclr) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      win_r  <= '0;
      op_r   <= OP_HOLD;
      mask_r <= '0;
    end else begin
      if (state == ST_IDLE && found && !sclr) win_r <= pick;
      if (state == ST_LATCH) begin
        op_r   <= op_t'(op[2*win_r +: 2]);
        mask_r <= mask[WIDTH*win_r +: WIDTH];
      end
      if (state == ST_ACK && !sclr)
        ptr <= (32'(win_r) == NREQ - 1) ? '0 : win_r + 1'b1;
    end
  end

  // The op code is literally {J,K}, so each masked bit takes J/K straight
  // from the code; a synchronous clear forces K on every bit instead.
  always_comb begin
    j_v = '0;
    k_v = '0;
    if (sclr) begin
      k_v = '1;
    end else if (state == ST_APPLY) begin
      j_v = mask_r & {WIDTH{op_r[1]}};
      k_v = mask_r & {WIDTH{op_r[0]}};
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    jk_ff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_v[b]),
      .k     (k_v[b]),
      .q     (q[b]),
      .qb    (qb[b])
    );
  end

  always_comb begin
    gnt = '0;
    if (state == ST_ACK) gnt[win_r] = 1'b1;
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_jk_bank_sched.sv
// tb_jk_bank_sched: directed self-checking bench for jk_bank_sched
// (NREQ=4, WIDTH=8). Define JK_SCHED_SCLR_EN to include the sync_clr case.
module tb_jk_bank_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_clr;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] mask;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  qb;

  int checks = 0;
  int errors = 0;

  jk_bank_sched #(.NREQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef JK_SCHED_SCLR_EN
    .sync_clr (sync_clr),
`endif
    .req      (req),
    .op       (op),
    .mask     (mask),
    .gnt      (gnt),
    .busy     (busy),
    .q        (q),
    .qb       (qb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction; req drops after sampling and op/mask are scrambled
  // after the capture edge, neither of which may affect the result.
  task automatic do_txn(input logic [3:0] r, input logic [7:0] o, input logic [31:0] m,
                        output int lat, output logic [3:0] g);
    lat = 0;
    g   = '0;
    req = r; op = o; mask = m;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) req = '0;
      if (i == 2) begin op = ~o; mask = ~m; end
      if (gnt != 4'b0) begin lat = i; g = gnt; break; end
    end
    tick();
    op = '0; mask = '0;
  endtask

  int          lat;
  logic [3:0]  g;
  int          n;
  int          gcyc[5];
  logic [3:0]  gv[5];
  logic [3:0]  exp_g[5];
  logic [3:0]  gacc;

  initial begin
    rst_n = 1'b0; sync_clr = 1'b0; req = '0; op = '0; mask = '0;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    #2;
    check("rst_q",    32'(q),    32'h00);
    check("rst_qb",   32'(qb),   32'hFF);
    check("rst_gnt",  32'(gnt),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_q",    32'(q),    32'h00);
    check("post_rst_qb",   32'(qb),   32'hFF);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Requester 1 SET on low nibble.
    do_txn(4'b0010, 8'h08, 32'h0000_0F00, lat, g);
    check("t1_lat",  32'(lat),  32'd3);
    check("t1_gnt",  32'(g),    32'h2);
    check("t1_q",    32'(q),    32'h0F);
    check("t1_qb",   32'(qb),   32'hF0);
    check("t1_busy", 32'(busy), 32'h0);

    // Requester 0 TOG all bits.
    do_txn(4'b0001, 8'h03, 32'h0000_00FF, lat, g);
    check("t2_gnt", 32'(g), 32'h1);
    check("t2_q",   32'(q), 32'hF0);

    // Requester 0 TOG with empty mask: no-op but still granted.
    do_txn(4'b0001, 8'h03, 32'h0000_0000, lat, g);
    check("t3_lat", 32'(lat), 32'd3);
    check("t3_gnt", 32'(g),   32'h1);
    check("t3_q",   32'(q),   32'hF0);

    // Requester 3 CLR upper nibble; leaves pointer at 0.
    do_txn(4'b1000, 8'h40, 32'hF000_0000, lat, g);
    check("t4_gnt", 32'(g), 32'h8);
    check("t4_q",   32'(q), 32'h00);

    // Fairness with all requesters held.
    req = 4'hF; op = '0; mask = '0; n = 0;
    for (int c = 1; c <= 40 && n < 5; c++) begin
      tick();
      if (gnt != 4'b0) begin gcyc[n] = c; gv[n] = gnt; n++; end
    end
    req = '0;
    tick();
    check("fair_count", 32'(n), 32'd5);
    for (int k = 0; k < n; k++) begin
      check("fair_gnt", 32'(gv[k]),   32'(exp_g[k]));
      check("fair_cyc", 32'(gcyc[k]), 32'(3 + 4 * k));
    end
    check("fair_busy", 32'(busy), 32'h0);

    // Requester 2 SET 0x3C (pointer 1 -> winner 2).
    do_txn(4'b0100, 8'h20, 32'h003C_0000, lat, g);
    check("t5_gnt", 32'(g), 32'h4);
    check("t5_q",   32'(q), 32'h3C);

    // Reset asserted while in APPLY.
    req = 4'b1000; op = 8'hC0; mask = 32'hFF00_0000;
    tick();
    req = '0;
    tick();
    check("mid_busy_apply", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_q",    32'(q),    32'h00);
    check("mid_qb",   32'(qb),   32'hFF);
    check("mid_busy", 32'(busy), 32'h0);
    gacc = gnt;
    for (int i = 0; i < 3; i++) begin tick(); gacc |= gnt; end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); gacc |= gnt; end
    check("mid_no_gnt", 32'(gacc), 32'h0);
    check("mid_q_after", 32'(q), 32'h00);
    do_txn(4'b1111, 8'h00, 32'h0, lat, g);
    check("mid_next_gnt", 32'(g),   32'h1);
    check("mid_next_lat", 32'(lat), 32'd3);

`ifdef JK_SCHED_SCLR_EN
    // Requester 1 SET 0xAA, pointer then 2.
    do_txn(4'b0010, 8'h08, 32'h0000_AA00, lat, g);
    check("sc_setup_q", 32'(q), 32'hAA);
    req = 4'b0100; op = 8'h30; mask = 32'h00FF_0000;
    tick();
    req = '0;
    check("sc_latch_busy", 32'(busy), 32'h1);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    check("sc_q",    32'(q),    32'h00);
    check("sc_busy", 32'(busy), 32'h0);
    gacc = gnt;
    for (int i = 0; i < 4; i++) begin tick(); gacc |= gnt; end
    check("sc_no_gnt", 32'(gacc), 32'h0);
    check("sc_q_hold", 32'(q),    32'h00);
    do_txn(4'b1111, 8'h00, 32'h0, lat, g);
    check("sc_ptr_kept", 32'(g), 32'h4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/jk_bank_sched.md
JK_BANK_SCHED -- requirements
Module: jk_bank_sched

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL provide parameter WIDTH, default 8, number of JK bits in the bank.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NREQ  per-requester request level.
REQ-006 SHALL have port op  input  2*NREQ  per-requester {J,K} code; requester i at bits [2i+1:2i].
REQ-007 SHALL have port mask  input  WIDTH*NREQ  per-requester bit-select; requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-008 SHALL have port gnt  output  NREQ  one-hot, one-cycle completion pulse.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port q  output  WIDTH  bank state.
REQ-011 SHALL have port qb  output  WIDTH  always equal to ~q.

Function
REQ-012 SHALL implement the FSM IDLE -> LATCH -> APPLY -> ACK -> IDLE, advancing one state per clock.
REQ-013 SHALL leave IDLE only when req is nonzero, and SHALL stay in IDLE otherwise.
REQ-014 SHALL select the winner in IDLE by round-robin search from pointer ptr upward, with wrap at NREQ.
REQ-015 SHALL capture the winner index, op and mask in LATCH; req, op and mask changes after that edge do not affect the transaction.
REQ-016 SHALL update q at the APPLY edge, per bit: mask=0 or op=00 hold; 01 clear; 10 set; 11 toggle.
REQ-017 SHALL assert gnt[winner] only during ACK; latency from req sampled in IDLE to gnt is 3 cycles.
REQ-018 SHALL set ptr to winner+1 mod NREQ in ACK.
REQ-019 SHALL let a requester keep req high after gnt and be re-arbitrated next IDLE; a requester dropping req before IDLE sampling is not served.
REQ-020 SHALL complete a transaction whose mask is all-zero as a normal no-op (q unchanged, gnt pulsed).
REQ-021 SHALL not depend on a combinational path from req, op or mask to gnt, busy or q.

Reset
REQ-022 SHALL, while rst_n=0 (asynchronous assert), hold q=0, qb=all ones, gnt=0, busy=0, state=IDLE, ptr=0.
REQ-023 SHALL, on reset mid-transaction, discard the transaction with no gnt issued.
REQ-024 SHALL evaluate the first arbitration at the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with JK_SCHED_SCLR_EN defined, add input sync_clr (1 bit). When sync_clr is high at an edge: q<=0, state<=IDLE, gnt<=0, ptr unchanged, any in-flight transaction is dropped without gnt, and sync_clr has priority over APPLY.
REQ-026 SHALL, without JK_SCHED_SCLR_EN, omit the sync_clr port and its logic entirely.

Structure
REQ-027 SHALL place the op encodings (HOLD=00, CLR=01, SET=10, TOG=11), the state enum and the parameter defaults in package jk_sched_pkg.
REQ-028 SHALL build the bank from WIDTH instances of sub-module jk_ff_cell (one JK bit with async active-low reset, q and qb outputs).

Verification
REQ-029 SHALL cover reset: after rst_n low then high, q=8'h00, qb=8'hFF, gnt=0, busy=0.
REQ-030 SHALL cover single op: req=4'b0010, op[3:2]=10, mask[15:8]=8'h0F -> q=8'h0F, gnt=4'b0010 exactly 3 cycles after sampling.
REQ-031 SHALL cover toggle: with q=8'h0F, requester 0 op=11, mask=8'hFF -> q=8'hF0; with mask=8'h00 -> q unchanged, gnt pulsed.
REQ-032 SHALL cover fairness: req=4'b1111 held -> gnt order 0,1,2,3,0 with one gnt every 4 cycles.
REQ-033 SHALL cover reset mid-transaction: rst_n low during APPLY -> q=0, no gnt, next grant goes to requester 0.
REQ-034 SHALL cover sync_clr (macro defined): sync_clr high in LATCH with q=8'hAA -> q=8'h00, no gnt, busy low the next cycle.
